// File: rtl/demux8_pkg.sv
// Shared constants for the A/B byte distribution path.
// Holds the byte width, the select encodings and the default FIFO depth.
package demux8_pkg;

    localparam int DATA_W    = 8;
    localparam int DEPTH_DEF = 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Purpose: small byte FIFO whose storage is cleared on reset; the head byte is read straight from storage.
// Latency: a byte pushed at edge N is at head_data with valid=1 after edge N.
// Backpressure: full is raised at DEPTH entries; a push while full is ignored and never bypasses to the head.
module byte_fifo
    import demux8_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              valid,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    byte_t             mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so that DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign valid     = (count != '0);
    assign head_data = mem[rptr];

    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ptr_inc(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_inc(rptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux8_buf.sv
// Purpose: routes each accepted byte to FIFO A (sel=0) or FIFO B (sel=1).
// Latency: one cycle from accept to the byte appearing at the selected output.
// Backpressure: in_ready reflects only the selected FIFO's fullness; a stalled side never blocks the other.
module demux8_buf
    import demux8_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [CNT_W-1:0]  a_count,
    output logic [CNT_W-1:0]  b_count
);

    logic full_a;
    logic full_b;
    logic accept;
    logic push_a;
    logic push_b;

    // Readiness looks at registered fullness only, so a pop never frees a slot in the same cycle.
    assign in_ready = (in_sel == SEL_B) ? !full_b : !full_a;
    assign accept   = in_valid && in_ready;
    assign push_a   = accept && (in_sel == SEL_A);
    assign push_b   = accept && (in_sel == SEL_B);

    byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head_data (a_data),
        .valid     (a_valid),
        .full      (full_a),
        .count     (a_count)
    );

    byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head_data (b_data),
        .valid     (b_valid),
        .full      (full_b),
        .count     (b_count)
    );

endmodule

// File: doc/demux8_buf.md
Name: demux8_buf

Overview:
- Buffered 1-to-2 byte demultiplexer; the distribution end of the 8-bit A/B select path.
- Accepts one 8-bit stream with valid/ready handshake and routes each accepted byte to output A (sel=0) or output B (sel=1).
- Each output has its own small FIFO, so a stalled consumer on one side does not block traffic to the other side.
- Sits between a single bus driver and two independent byte consumers, e.g. register-file write ports.

Parameters:
- DEPTH, 2: entries per output FIFO; integer >= 2, need not be a power of 2.
- CNT_W, 2: width of the occupancy count outputs; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  byte to route.
- in_sel  input  1  destination select: 0 routes to A, 1 routes to B; sampled with in_data.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept this cycle.
- a_data  output  8  head byte of FIFO A.
- a_valid  output  1  FIFO A non-empty.
- a_ready  input  1  consumer A takes the head.
- b_data  output  8  head byte of FIFO B.
- b_valid  output  1  FIFO B non-empty.
- b_ready  input  1  consumer B takes the head.
- a_count  output  CNT_W  occupancy of FIFO A.
- b_count  output  CNT_W  occupancy of FIFO B.

Behaviour:
- Single clock domain clk. Reset is asynchronous, active-low, on rst_n; assertion takes effect immediately, deassertion is synchronous to clk.
- Reset values:
  - a_valid=0, b_valid=0, a_count=0, b_count=0.
  - a_data=8'h00, b_data=8'h00 (storage cleared).
  - All read/write pointers 0.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready on a rising edge.
  - Output transfer occurs when x_valid && x_ready.
  - in_ready = in_sel ? !full_B : !full_A. This is combinational from in_sel and registered state only; it never depends on a_ready or b_ready (no full-FIFO bypass).
  - Upstream must hold in_data/in_sel stable while in_valid=1 and in_ready=0.
- Latency:
  - A byte accepted at edge N is visible on x_data with x_valid=1 after edge N, i.e. one cycle.
  - No combinational path from in_data to any output.
- Ordering: FIFO order is preserved per output. There is no ordering relation between the A and B streams.
- Per-FIFO update on each edge (push = accepted byte targeted here, pop = output transfer):
  - push only: write at wptr, count+1.
  - pop only: rptr advances, count-1.
  - push and pop together: both pointers advance, count unchanged. This is legal whenever not full, including count=1.
  - A push into an empty FIFO and a pop in the same cycle cannot occur, because valid=0 when empty.
- Wrap-around: a pointer equal to DEPTH-1 goes to 0 on advance.
- full = (count==DEPTH); empty = (count==0); x_valid = !empty; x_data = mem[rptr].
- Full boundary: with the FIFO full and x_ready=1 in the same cycle, in_ready for that side stays 0. The slot is reused from the next cycle.
- in_sel toggling while in_valid=0 has no effect.
- Reset mid-operation: all buffered bytes are discarded and outputs return to their reset values immediately (asynchronous). The first accept is possible on the first edge after rst_n rises.
- No overflow or underflow is possible by construction. Bytes offered while in_ready=0 are not lost; they are held upstream.

Decomposition:
- Shared package demux8_pkg:
  - DATA_W=8.
  - SEL_A=1'b0, SEL_B=1'b1.
  - Default DEPTH=2.
- Sub-module byte_fifo:
  - Parameterised on DEPTH.
  - Ports: clk, rst_n, push, push_data, pop, head_data, valid, full, count.
  - Instantiated twice, once for A and once for B.
- Top level holds only the select steering and in_ready logic.

Test Plan:
- Reset and single byte to A: rst_n low then high. Send 8'hA5 with sel=0, a_ready=1. Expect a_valid=1 and a_data=A5 one cycle after accept; b_valid stays 0; a_count goes 1 then 0.
- Fill B to full: b_ready=0, send 8'h11, 8'h22 with sel=1 (DEPTH=2). Expect b_count=2, in_ready=0 while sel=1, in_ready=1 when sel switches to 0. Send 8'h33 to A while B is full; expect it accepted.
- Full plus simultaneous pop: B full with 8'h11, 8'h22. Raise b_ready for one cycle with in_valid=1, sel=1, 8'h44. Expect no accept that cycle, 11 popped, b_count=1. Next cycle 44 is accepted, and B then delivers 22 followed by 44.
- Streaming with wrap-around: 10 bytes 8'h00..8'h09 to A with a_ready=1 continuously. Expect in_ready=1 throughout, a_count holding at 1 during steady state, output sequence 00..09 in order across multiple pointer wraps.
- Interleaved routing: sequence (A,01),(B,02),(A,03),(B,04) with both readies=1. Expect A receives 01,03 and B receives 02,04, each one cycle after its accept.
- Async reset mid-operation: with a_count=2 and b_count=1, pulse rst_n low between clock edges. Expect a_valid, b_valid and both counts to go 0 immediately without a clock edge. After release, 8'h7E to B is delivered as the first B byte.
